// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in per-source FIFOs and
// broadcasts one registered result per cycle under round-robin arbitration.
module cdb_arbiter #(
    parameter int unsigned ROB_INDEX_BIT = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FIFO_PTR_BIT  = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     alu_valid,
    input  logic [ROB_INDEX_BIT-1:0] alu_rob_id,
    input  logic [31:0]              alu_val,
    input  logic                     lsb_valid,
    input  logic [ROB_INDEX_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_val,
    output logic                     alu_full,
    output logic                     lsb_full,
    output logic                     cdb_valid,
    output logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
    output logic [31:0]              cdb_val,
    output logic                     cdb_src,
    output logic                     overflow
);

    localparam int unsigned CntBits = FIFO_PTR_BIT + 1;

    // Source index 0 is the ALU, 1 is the LSB, matching cdb_src encoding.
    logic                     in_valid [2];
    logic [ROB_INDEX_BIT-1:0] in_id    [2];
    logic [31:0]              in_val   [2];

    logic [ROB_INDEX_BIT-1:0] fifo_id_q  [2][FIFO_DEPTH];
    logic [31:0]              fifo_val_q [2][FIFO_DEPTH];
    logic [FIFO_PTR_BIT-1:0]  rd_ptr_q   [2];
    logic [FIFO_PTR_BIT-1:0]  wr_ptr_q   [2];
    logic [CntBits-1:0]       cnt_q      [2];
    logic [CntBits-1:0]       cnt_d      [2];
    logic                     full_q     [2];
    logic                     last_grant_q;

    logic                     has_head [2];
    logic                     cand     [2];
    logic                     pop      [2];
    logic                     push     [2];
    logic                     drop     [2];
    logic                     any_grant;
    logic                     winner;
    logic [ROB_INDEX_BIT-1:0] win_id;
    logic [31:0]              win_val;

    assign in_valid[0] = alu_valid;
    assign in_id[0]    = alu_rob_id;
    assign in_val[0]   = alu_val;
    assign in_valid[1] = lsb_valid;
    assign in_id[1]    = lsb_rob_id;
    assign in_val[1]   = lsb_val;

    assign alu_full = full_q[0];
    assign lsb_full = full_q[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            has_head[s] = (cnt_q[s] != '0);
            cand[s]     = has_head[s] | in_valid[s];
        end

        any_grant = cand[0] | cand[1];
        winner    = (cand[0] && cand[1]) ? ~last_grant_q : cand[1];

        for (int s = 0; s < 2; s++) begin
            logic granted;
            logic push_req;
            granted  = any_grant && (winner == 1'(s));
            pop[s]   = granted && has_head[s];
            // A word granted straight from the input bypasses the FIFO.
            push_req = in_valid[s] && !(granted && !has_head[s]);
            drop[s]  = push_req && (cnt_q[s] == CntBits'(FIFO_DEPTH)) && !pop[s];
            push[s]  = push_req && !drop[s];
            cnt_d[s] = cnt_q[s] + CntBits'(push[s]) - CntBits'(pop[s]);
        end

        win_id  = has_head[winner] ? fifo_id_q[winner][rd_ptr_q[winner]] : in_id[winner];
        win_val = has_head[winner] ? fifo_val_q[winner][rd_ptr_q[winner]] : in_val[winner];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
                full_q[s]   <= 1'b0;
            end
            cdb_valid    <= 1'b0;
            cdb_rob_id   <= '0;
            cdb_val      <= '0;
            cdb_src      <= 1'b0;
            overflow     <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (rdy_in) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    fifo_id_q[s][wr_ptr_q[s]]  <= in_id[s];
                    fifo_val_q[s][wr_ptr_q[s]] <= in_val[s];
                end
                wr_ptr_q[s] <= wr_ptr_q[s] + FIFO_PTR_BIT'(push[s]);
                rd_ptr_q[s] <= rd_ptr_q[s] + FIFO_PTR_BIT'(pop[s]);
                cnt_q[s]    <= cnt_d[s];
                // Asserted one entry early so a result already in flight still fits.
                full_q[s]   <= (cnt_d[s] >= CntBits'(FIFO_DEPTH - 1));
            end
            overflow <= overflow | drop[0] | drop[1];
            if (any_grant) begin
                cdb_valid    <= 1'b1;
                cdb_rob_id   <= win_id;
                cdb_val      <= win_val;
                cdb_src      <= winner;
                last_grant_q <= winner;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, bypass, ties, streaming,
// overflow, clear and pause behaviour with hand-derived expected broadcasts.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        av = 1'b0;
    logic [3:0]  aid = '0;
    logic [31:0] aval = '0;
    logic        lv = 1'b0;
    logic [3:0]  lid = '0;
    logic [31:0] lval = '0;
    logic        alu_full, lsb_full, cdb_valid, cdb_src, overflow;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_val;

    int n_cmp = 0;
    int n_err = 0;

    logic [37:0] got_w, exp_w;

    cdb_arbiter #(.ROB_INDEX_BIT(4), .FIFO_DEPTH(4), .FIFO_PTR_BIT(2)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
        .alu_valid(av), .alu_rob_id(aid), .alu_val(aval),
        .lsb_valid(lv), .lsb_rob_id(lid), .lsb_val(lval),
        .alu_full(alu_full), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .cdb_src(cdb_src), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        av = 1'b0; aid = '0; aval = '0;
        lv = 1'b0; lid = '0; lval = '0;
    endtask

    task automatic drive(input logic a_v, input logic [3:0] a_id, input logic [31:0] a_val,
                         input logic l_v, input logic [3:0] l_id, input logic [31:0] l_val);
        av = a_v; aid = a_id; aval = a_val;
        lv = l_v; lid = l_id; lval = l_val;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'd3, 32'h77, 1'b1, 4'd4, 32'h88);
        tick();
        n_cmp++;
        if ({cdb_valid, cdb_src, alu_full, lsb_full, overflow} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {cdb_valid, cdb_src, alu_full, lsb_full, overflow});
        end
        n_cmp++;
        if ({cdb_rob_id, cdb_val} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_word: got %h want 0", {cdb_rob_id, cdb_val});
        end
        rst = 1'b0;
        idle();
        tick();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_discard: got cdb_valid=%b want 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0);
        tick();
        got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
        n_cmp++;
        if (got_w !== {1'b1, 1'b0, 4'd3, 32'h11}) begin
            n_err++;
            $display("FAIL single_bypass: got %h want %h", got_w, {1'b1, 1'b0, 4'd3, 32'h11});
        end
        idle();
        tick();
        got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
        n_cmp++;
        if (got_w !== {1'b0, 1'b0, 4'd3, 32'h11}) begin
            n_err++;
            $display("FAIL single_hold: got %h want %h", got_w, {1'b0, 1'b0, 4'd3, 32'h11});
        end
    endtask

    task automatic test_tie();
        do_reset();
        drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        tick();
        got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
        n_cmp++;
        if (got_w !== {1'b1, 1'b0, 4'd1, 32'hA}) begin
            n_err++;
            $display("FAIL tie_first: got %h want %h", got_w, {1'b1, 1'b0, 4'd1, 32'hA});
        end
        n_cmp++;
        if ({alu_full, lsb_full} !== 2'b00) begin
            n_err++;
            $display("FAIL tie_full: got %b want 00", {alu_full, lsb_full});
        end
        idle();
        tick();
        got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
        n_cmp++;
        if (got_w !== {1'b1, 1'b1, 4'd2, 32'hB}) begin
            n_err++;
            $display("FAIL tie_second: got %h want %h", got_w, {1'b1, 1'b1, 4'd2, 32'hB});
        end
        tick();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL tie_drain: got cdb_valid=%b want 0", cdb_valid);
        end
    endtask

    // Six cycles of both sources: strict alternation 0,8,1,9,... then a drain.
    task automatic test_both_stream();
        logic [12:0] exp_af;
        logic [12:0] exp_lf;
        exp_af = 13'b0_0000_0010_0000;
        exp_lf = 13'b0_0000_0111_0000;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i < 6) drive(1'b1, 4'(i), 32'h100 + i, 1'b1, 4'(8 + i), 32'h208 + i);
            else idle();
            tick();
            if (i == 12) exp_w = '0;
            else if (i % 2 == 0) exp_w = {1'b1, 1'b0, 4'(i / 2), 32'h100 + i / 2};
            else exp_w = {1'b1, 1'b1, 4'(8 + (i - 1) / 2), 32'h208 + (i - 1) / 2};
            got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
            n_cmp++;
            if ((i < 12 && got_w !== exp_w) || (i == 12 && cdb_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL both_word[%0d]: got %h want %h", i, got_w, exp_w);
            end
            n_cmp++;
            if ({alu_full, lsb_full} !== {exp_af[i], exp_lf[i]}) begin
                n_err++;
                $display("FAIL both_full[%0d]: got %b want %b", i, {alu_full, lsb_full},
                         {exp_af[i], exp_lf[i]});
            end
        end
    endtask

    // Nine cycles of both sources: the LSB's ninth word finds its FIFO full and is dropped.
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 9) drive(1'b1, 4'(i), 32'hA00 + i, 1'b1, 4'(i), 32'hB00 + i);
            else idle();
            tick();
            if (i == 17) exp_w = '0;
            else if (i % 2 == 0) exp_w = {1'b1, 1'b0, 4'(i / 2), 32'hA00 + i / 2};
            else exp_w = {1'b1, 1'b1, 4'((i - 1) / 2), 32'hB00 + (i - 1) / 2};
            got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
            n_cmp++;
            if ((i < 17 && got_w !== exp_w) || (i == 17 && cdb_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL ovf_word[%0d]: got %h want %h", i, got_w, exp_w);
            end
            n_cmp++;
            if (overflow !== (i >= 8)) begin
                n_err++;
                $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow, (i >= 8));
            end
        end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 4'(k), 32'h300 + k, 1'b1, 4'(8 + k), 32'h400 + k);
            tick();
        end
        clr = 1'b1;
        drive(1'b1, 4'd7, 32'h777, 1'b1, 4'd7, 32'h777);
        tick();
        n_cmp++;
        if ({cdb_valid, cdb_src, alu_full, lsb_full, overflow, cdb_rob_id, cdb_val} !== 41'h0) begin
            n_err++;
            $display("FAIL clear_state: got %h want 0",
                     {cdb_valid, cdb_src, alu_full, lsb_full, overflow, cdb_rob_id, cdb_val});
        end
        clr = 1'b0;
        idle();
        tick();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clear_empty: got cdb_valid=%b want 0", cdb_valid);
        end
        drive(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66);
        tick();
        got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
        n_cmp++;
        if (got_w !== {1'b1, 1'b0, 4'd5, 32'h55}) begin
            n_err++;
            $display("FAIL clear_alu_first: got %h want %h", got_w, {1'b1, 1'b0, 4'd5, 32'h55});
        end
        idle();
        tick();
        got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
        n_cmp++;
        if (got_w !== {1'b1, 1'b1, 4'd6, 32'h66}) begin
            n_err++;
            $display("FAIL clear_lsb_next: got %h want %h", got_w, {1'b1, 1'b1, 4'd6, 32'h66});
        end
    endtask

    task automatic test_pause();
        logic [3:0] exp_ids [4];
        exp_ids[0] = 4'd2; exp_ids[1] = 4'd10; exp_ids[2] = 4'd3; exp_ids[3] = 4'd11;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'(k), 32'h100 + k, 1'b1, 4'(8 + k), 32'h208 + k);
            tick();
        end
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k % 2 == 0, 4'd14, 32'hEEE, k % 2 == 0, 4'd15, 32'hFFF);
            tick();
            got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
            n_cmp++;
            if (got_w !== {1'b1, 1'b1, 4'd9, 32'h209} ||
                {alu_full, lsb_full, overflow} !== 3'b000) begin
                n_err++;
                $display("FAIL pause_hold[%0d]: got %h/%b want %h/000", k, got_w,
                         {alu_full, lsb_full, overflow}, {1'b1, 1'b1, 4'd9, 32'h209});
            end
        end
        rdy = 1'b1;
        idle();
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) exp_w = '0;
            else if (k % 2 == 0) exp_w = {1'b1, 1'b0, exp_ids[k], 32'h100 + 32'(exp_ids[k])};
            else exp_w = {1'b1, 1'b1, exp_ids[k], 32'h200 + 32'(exp_ids[k])};
            got_w = {cdb_valid, cdb_src, cdb_rob_id, cdb_val};
            n_cmp++;
            if ((k < 4 && got_w !== exp_w) || (k == 4 && cdb_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL pause_resume[%0d]: got %h want %h", k, got_w, exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_both_stream();
        test_overflow();
        test_clear();
        test_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
